frame_addr_gen: RTL and testbench
=================================

FRAME_ADDR_GEN -- requirements
Module: frame_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, address and counter width.
REQ-002 SHALL have parameter DIM_W, default 16, width of the width/height inputs.
REQ-003 SHALL have parameter HDR_WORDS, default 2, number of header words issued before pixel data.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  begin a frame; sampled only in IDLE or DONE.
REQ-007 SHALL have port count_en  input  1  consumer accepted current r_addr; advance.
REQ-008 SHALL have port width  input  DIM_W  frame width in pixels; latched on an accepted start.
REQ-009 SHALL have port height  input  DIM_W  frame height in pixels; latched on an accepted start.
REQ-010 SHALL have port mode  input  2  chroma format; latched on an accepted start: 0=4:2:0, 1=4:2:2, 2=4:4:4, 3=mono.
REQ-011 SHALL have port base_addr  input  ADDR_W  first address; latched on an accepted start.
REQ-012 SHALL have port r_addr  output  ADDR_W  current read address.
REQ-013 SHALL have port plane  output  2  region of r_addr: 0=header, 1=Y, 2=U, 3=V.
REQ-014 SHALL have port busy  output  1  high in LOAD, HDR, Y, U and V.
REQ-015 SHALL have port count_done  output  1  level; frame complete.
REQ-016 SHALL have port done_pulse  output  1  one-cycle strobe on entry to DONE.

Function
REQ-017 SHALL implement the states IDLE, LOAD, HDR, Y, U, V and DONE.
REQ-018 SHALL, in IDLE or DONE with start=1, latch the inputs, clear count_done and enter LOAD.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL, in LOAD (exactly 1 cycle), register the 2*DIM_W-bit products: ysize=W*H; csize=(W*H)>>2 for mode 0, (W*H)>>1 for mode 1, W*H for mode 2, 0 for mode 3; SHALL set r_addr=base_addr; SHALL go to HDR.
REQ-021 SHALL truncate all address arithmetic modulo 2^ADDR_W, so r_addr wraps silently.
REQ-022 SHALL, in HDR/Y/U/V, increment r_addr by 1 and decrement the region counter on each cycle with count_en=1, and SHALL hold both otherwise.
REQ-023 SHALL leave a region after its last accepted word, moving to the next non-empty region in the order HDR, Y, U, V.
REQ-024 SHALL, after the final region, enter DONE; total accepted words = HDR_WORDS+ysize+2*csize.
REQ-025 SHALL skip regions of size 0 with no cycle spent (HDR_WORDS=0, W or H = 0, mono chroma); if all are empty, LOAD goes straight to DONE.
REQ-026 SHALL, in DONE, hold count_done=1 and r_addr equal to last address+1 until clear or an accepted start.
REQ-027 SHALL ignore count_en in IDLE, LOAD and DONE.
REQ-028 SHALL, with start and count_en both high in DONE, treat the cycle as a restart only.
REQ-029 SHALL derive plane from the state; plane=0 in IDLE/LOAD/DONE.

Reset
REQ-030 SHALL make clear override all other inputs, including mid-frame, and return the block to IDLE on the next edge.
REQ-031 SHALL, on clear, set r_addr=0, plane=0, busy=0, count_done=0, done_pulse=0, region counters=0, and ovf=0 where present.

Configuration
REQ-032 SHALL provide macro FRAME_ADDR_GEN_OVF_CHECK_EN.
REQ-033 SHALL, with the macro defined, add output ovf (1 bit), set in LOAD when base_addr+total exceeds 2^ADDR_W and held until clear or the next accepted start; the address sequence is unchanged.
REQ-034 SHALL, with the macro undefined, have no ovf port and no compare logic.

Verification
REQ-035 SHALL cover: base=0x100, W=4, H=2, mode 0, count_en=1 continuously -> addresses 0x100..0x10D (14 words); plane 0 x2, 1 x8, 2 x2, 3 x2; done_pulse for 1 cycle; r_addr=0x10E held.
REQ-036 SHALL cover: W=4, H=2, mode 3, count_en toggling 1/0 -> 10 accepted words, r_addr stalls on 0 cycles, plane never 2 or 3.
REQ-037 SHALL cover: W=0, H=5, mode 2, HDR_WORDS=2 -> 2 header words, then DONE.
REQ-038 SHALL cover: clear asserted on the 5th Y word of a 4:4:4 frame -> next cycle IDLE, all outputs 0; new start runs a full frame from base.
REQ-039 SHALL cover: ADDR_W=18, base=0x3FFFE, W=2, H=2, mode 2 -> r_addr wraps 0x3FFFF to 0x00000; ovf=1 only when built with FRAME_ADDR_GEN_OVF_CHECK_EN.
REQ-040 SHALL cover: start pulsed mid-frame -> ignored; start in DONE with new W/H -> LOAD, count_done falls the next cycle.

Source files
------------

// File: rtl/frame_addr_gen_if.sv
// -----------------------------------------------------------------------------
// frame_addr_gen_if
// Bundles the control and address signals of the frame address generator.
//   master : drives start/count_en and the frame descriptor
//            (width, height, mode, base_addr); observes r_addr, plane, busy,
//            count_done, done_pulse (and ovf when
//            FRAME_ADDR_GEN_OVF_CHECK_EN is defined).
//   slave  : the generator side of the same signals.
// -----------------------------------------------------------------------------
interface frame_addr_gen_if #(
  parameter int ADDR_W = 18,
  parameter int DIM_W  = 16
);
  logic              start;
  logic              count_en;
  logic [DIM_W-1:0]  width;
  logic [DIM_W-1:0]  height;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        plane;
  logic              busy;
  logic              count_done;
  logic              done_pulse;
`ifdef FRAME_ADDR_GEN_OVF_CHECK_EN
  logic              ovf;

  modport master (
    output start, count_en, width, height, mode, base_addr,
    input  r_addr, plane, busy, count_done, done_pulse, ovf
  );
  modport slave (
    input  start, count_en, width, height, mode, base_addr,
    output r_addr, plane, busy, count_done, done_pulse, ovf
  );
`else
  modport master (
    output start, count_en, width, height, mode, base_addr,
    input  r_addr, plane, busy, count_done, done_pulse
  );
  modport slave (
    input  start, count_en, width, height, mode, base_addr,
    output r_addr, plane, busy, count_done, done_pulse
  );
`endif
endinterface

// File: rtl/frame_addr_gen.sv
// -----------------------------------------------------------------------------
// frame_addr_gen
// Generates the read address sequence for one video frame: HDR_WORDS header
// words, then the Y plane, then the U and V chroma planes, each sized from the
// frame dimensions and the chroma format. Each address is held until the
// consumer accepts it with count_en.
//
// Ports
//   clk    : single clock, rising edge
//   clear  : synchronous active-high reset, overrides everything
//   bus    : frame_addr_gen_if.slave
//              in : start, count_en, width, height, mode, base_addr
//              out: r_addr, plane, busy, count_done, done_pulse [, ovf]
//
// Build option
//   FRAME_ADDR_GEN_OVF_CHECK_EN : adds bus.ovf, flagging a frame whose
//   address range runs past 2^ADDR_W (addresses still wrap silently).
// -----------------------------------------------------------------------------
module frame_addr_gen #(
  parameter int ADDR_W    = 18,
  parameter int DIM_W     = 16,
  parameter int HDR_WORDS = 2
) (
  input  logic             clk,
  input  logic             clear,
  frame_addr_gen_if.slave  bus
);

  localparam int CNT_W = 2 * DIM_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HDR, S_Y, S_U, S_V, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  ysize_q, ysize_d;
  logic [CNT_W-1:0]  csize_q, csize_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_pulse_q, done_pulse_d;

  // Products computed from the latched dimensions, consumed only in LOAD.
  logic [CNT_W-1:0]  prod_y;
  logic [CNT_W-1:0]  prod_c;
  logic              last_word;

`ifdef FRAME_ADDR_GEN_OVF_CHECK_EN
  localparam int SUM_W = ((ADDR_W > CNT_W + 2) ? ADDR_W : CNT_W + 2) + 2;
  logic              ovf_q, ovf_d;
  logic [SUM_W-1:0]  end_sum;

  // One past the last address, without truncation.
  assign end_sum = SUM_W'(base_q) + SUM_W'(HDR_WORDS) + SUM_W'(prod_y)
                 + (SUM_W'(prod_c) << 1);
`endif

  always_comb begin
    prod_y = CNT_W'(width_q) * CNT_W'(height_q);
    case (mode_q)
      2'd0:    prod_c = prod_y >> 2;   // 4:2:0
      2'd1:    prod_c = prod_y >> 1;   // 4:2:2
      2'd2:    prod_c = prod_y;        // 4:4:4
      default: prod_c = '0;            // mono
    endcase
  end

  // The accepted word is the last one of the current region.
  assign last_word = bus.count_en && (cnt_q == CNT_W'(1));

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; that keeps this block purely combinational (no latches).
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    mode_d   = mode_q;
    base_d   = base_q;
    ysize_d  = ysize_q;
    csize_d  = csize_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
`ifdef FRAME_ADDR_GEN_OVF_CHECK_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          width_d  = bus.width;
          height_d = bus.height;
          mode_d   = bus.mode;
          base_d   = bus.base_addr;
`ifdef FRAME_ADDR_GEN_OVF_CHECK_EN
          ovf_d    = 1'b0;
`endif
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        ysize_d = prod_y;
        csize_d = prod_c;
        addr_d  = base_q;
`ifdef FRAME_ADDR_GEN_OVF_CHECK_EN
        ovf_d   = end_sum > (SUM_W'(1) << ADDR_W);
`endif
        // Empty regions are skipped here so no cycle is spent on them.
        if (HDR_WORDS != 0) begin
          state_d = S_HDR;
          cnt_d   = CNT_W'(HDR_WORDS);
        end else if (prod_y != '0) begin
          state_d = S_Y;
          cnt_d   = prod_y;
        end else if (prod_c != '0) begin
          state_d = S_U;
          cnt_d   = prod_c;
        end else begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end

      S_HDR, S_Y, S_U, S_V: begin
        if (bus.count_en) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - CNT_W'(1);
        end
        if (last_word) begin
          // Next non-empty region; U and V are always the same size.
          if (state_q == S_HDR && ysize_q != '0) begin
            state_d = S_Y;
            cnt_d   = ysize_q;
          end else if ((state_q == S_HDR || state_q == S_Y) && csize_q != '0) begin
            state_d = S_U;
            cnt_d   = csize_q;
          end else if (state_q == S_U) begin
            state_d = S_V;
            cnt_d   = csize_q;
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    done_pulse_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= S_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      mode_q       <= '0;
      base_q       <= '0;
      ysize_q      <= '0;
      csize_q      <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      mode_q       <= mode_d;
      base_q       <= base_d;
      ysize_q      <= ysize_d;
      csize_q      <= csize_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      done_pulse_q <= done_pulse_d;
    end
  end

`ifdef FRAME_ADDR_GEN_OVF_CHECK_EN
  always_ff @(posedge clk) begin
    if (clear) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`endif

  always_comb begin
    case (state_q)
      S_Y:     bus.plane = 2'd1;
      S_U:     bus.plane = 2'd2;
      S_V:     bus.plane = 2'd3;
      default: bus.plane = 2'd0;
    endcase
  end

  assign bus.r_addr     = addr_q;
  assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.count_done = (state_q == S_DONE);
  assign bus.done_pulse = done_pulse_q;

endmodule

// File: tb/tb_frame_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_frame_addr_gen
// Self-checking bench for frame_addr_gen. A reference model expands each frame
// descriptor into the list of (address, plane) words the generator must
// present, and every cycle the presented word is compared with the head of
// that list; accepted words are popped.
// -----------------------------------------------------------------------------
module tb_frame_addr_gen;

  localparam int ADDR_W    = 18;
  localparam int DIM_W     = 16;
  localparam int HDR_WORDS = 2;

  logic clk = 1'b0;
  logic clear;

  always #5 clk = ~clk;

  frame_addr_gen_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

  frame_addr_gen #(
    .ADDR_W   (ADDR_W),
    .DIM_W    (DIM_W),
    .HDR_WORDS(HDR_WORDS)
  ) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  int                exp_plane[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected word list: header, Y, U, V, consecutive addresses mod 2^ADDR_W.
  function automatic void build_model(input logic [ADDR_W-1:0] base,
                                      input int w, input int h,
                                      input logic [1:0] mode);
    longint            ysz;
    longint            csz;
    longint            sizes[4];
    logic [ADDR_W-1:0] a;
    ysz = longint'(w) * longint'(h);
    case (mode)
      2'd0:    csz = ysz / 4;
      2'd1:    csz = ysz / 2;
      2'd2:    csz = ysz;
      default: csz = 0;
    endcase
    sizes = '{longint'(HDR_WORDS), ysz, csz, csz};
    exp_addr.delete();
    exp_plane.delete();
    a = base;
    for (int p = 0; p < 4; p++) begin
      for (longint j = 0; j < sizes[p]; j++) begin
        exp_addr.push_back(a);
        exp_plane.push_back(p);
        a = a + 1'b1;
      end
    end
  endfunction

  // Runs one frame to completion and checks every presented word.
  //   en_mode : 0 = count_en always 1, 1 = toggling 1/0, 2 = random
  //   poke    : pulse start with different dimensions mid-frame
  //   started : start was already accepted by the caller (DUT is in LOAD)
  task automatic run_frame(input logic [ADDR_W-1:0] base, input int w,
                           input int h, input logic [1:0] mode,
                           input int en_mode, input bit poke,
                           input bit started, input string tag);
    int                n;
    int                idx;
    int                cyc;
    int                budget;
    bit                en;
    logic [ADDR_W-1:0] end_addr;
    bit                exp_ovf;

    build_model(base, w, h, mode);
    n        = exp_addr.size();
    end_addr = base + ADDR_W'(n);
    exp_ovf  = (longint'(base) + longint'(n)) > (longint'(1) << ADDR_W);

    if (!started) begin
      bus.width     = DIM_W'(w);
      bus.height    = DIM_W'(h);
      bus.mode      = mode;
      bus.base_addr = base;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
    end

    // LOAD cycle
    checks++;
    if (bus.busy !== 1'b1 || bus.count_done !== 1'b0 || bus.plane !== 2'd0 ||
        bus.done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL %s load_state: busy=%b done=%b plane=%0d pulse=%b, want 1 0 0 0",
               tag, bus.busy, bus.count_done, bus.plane, bus.done_pulse);
    end
`ifdef FRAME_ADDR_GEN_OVF_CHECK_EN
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s load_ovf: got %b want 0", tag, bus.ovf);
    end
`endif
    bus.count_en = 1'($urandom_range(0, 1));
    tick();

    idx    = 0;
    cyc    = 0;
    budget = 4 * n + 20;
    while (idx < n && cyc < budget) begin
      case (en_mode)
        0:       en = 1'b1;
        1:       en = (cyc % 2) == 0;
        default: en = 1'($urandom_range(0, 1));
      endcase
      bus.count_en = en;
      if (poke && cyc == 3) begin
        bus.start  = 1'b1;
        bus.width  = DIM_W'(w + 3);
        bus.height = DIM_W'(h + 1);
      end
      checks++;
      if (bus.r_addr !== exp_addr[idx] || bus.plane !== 2'(exp_plane[idx])) begin
        errors++;
        $display("FAIL %s word%0d: addr=%h plane=%0d, want addr=%h plane=%0d",
                 tag, idx, bus.r_addr, bus.plane, exp_addr[idx], exp_plane[idx]);
      end
      checks++;
      if (bus.busy !== 1'b1 || bus.count_done !== 1'b0 || bus.done_pulse !== 1'b0) begin
        errors++;
        $display("FAIL %s status%0d: busy=%b done=%b pulse=%b, want 1 0 0",
                 tag, idx, bus.busy, bus.count_done, bus.done_pulse);
      end
      tick();
      bus.start  = 1'b0;
      bus.width  = DIM_W'(w);
      bus.height = DIM_W'(h);
      if (en) idx++;
      cyc++;
    end
    checks++;
    if (idx < n) begin
      errors++;
      $display("FAIL %s timeout: accepted %0d of %0d words", tag, idx, n);
    end

    // First DONE cycle
    checks++;
    if (bus.count_done !== 1'b1 || bus.done_pulse !== 1'b1 || bus.busy !== 1'b0 ||
        bus.plane !== 2'd0 || bus.r_addr !== end_addr) begin
      errors++;
      $display("FAIL %s done_entry: done=%b pulse=%b busy=%b plane=%0d addr=%h, want 1 1 0 0 %h",
               tag, bus.count_done, bus.done_pulse, bus.busy, bus.plane, bus.r_addr, end_addr);
    end
`ifdef FRAME_ADDR_GEN_OVF_CHECK_EN
    checks++;
    if (bus.ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s ovf: got %b want %b", tag, bus.ovf, exp_ovf);
    end
`endif
    bus.count_en = 1'($urandom_range(0, 1));
    tick();
    checks++;
    if (bus.count_done !== 1'b1 || bus.done_pulse !== 1'b0 || bus.r_addr !== end_addr) begin
      errors++;
      $display("FAIL %s done_hold: done=%b pulse=%b addr=%h, want 1 0 %h (ovf model %b)",
               tag, bus.count_done, bus.done_pulse, bus.r_addr, end_addr, exp_ovf);
    end
    bus.count_en = 1'b0;
  endtask

  task automatic test_reset();
    clear         = 1'b1;
    bus.start     = 1'b0;
    bus.count_en  = 1'b0;
    bus.width     = '0;
    bus.height    = '0;
    bus.mode      = '0;
    bus.base_addr = '0;
    tick();
    tick();
    clear = 1'b0;
    checks++;
    if (bus.r_addr !== '0 || bus.plane !== 2'd0 || bus.busy !== 1'b0 ||
        bus.count_done !== 1'b0 || bus.done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset: addr=%h plane=%0d busy=%b done=%b pulse=%b, want all 0",
               bus.r_addr, bus.plane, bus.busy, bus.count_done, bus.done_pulse);
    end
    // count_en in IDLE must not move anything
    bus.count_en = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.r_addr !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_count_en: addr=%h busy=%b, want 0 0", bus.r_addr, bus.busy);
    end
    bus.count_en = 1'b0;
  endtask

  task automatic test_basic_420();
    run_frame(18'h00100, 4, 2, 2'd0, 0, 1'b0, 1'b0, "basic_420");
  endtask

  task automatic test_mono_toggle();
    run_frame(18'h01000, 4, 2, 2'd3, 1, 1'b0, 1'b0, "mono_toggle");
  endtask

  task automatic test_empty_pixels();
    run_frame(18'h02000, 0, 5, 2'd2, 2, 1'b0, 1'b0, "empty_pixels");
  endtask

  task automatic test_clear_mid_frame();
    bus.width     = 16'd4;
    bus.height    = 16'd4;
    bus.mode      = 2'd2;
    bus.base_addr = 18'h03000;
    bus.start     = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.count_en = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) tick();
    // Now presenting the fifth Y word
    checks++;
    if (bus.r_addr !== 18'h03006 || bus.plane !== 2'd1) begin
      errors++;
      $display("FAIL clear_pre: addr=%h plane=%0d, want 03006 1", bus.r_addr, bus.plane);
    end
    clear = 1'b1;
    tick();
    clear        = 1'b0;
    bus.count_en = 1'b0;
    checks++;
    if (bus.r_addr !== '0 || bus.plane !== 2'd0 || bus.busy !== 1'b0 ||
        bus.count_done !== 1'b0 || bus.done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid: addr=%h plane=%0d busy=%b done=%b pulse=%b, want all 0",
               bus.r_addr, bus.plane, bus.busy, bus.count_done, bus.done_pulse);
    end
`ifdef FRAME_ADDR_GEN_OVF_CHECK_EN
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid_ovf: got %b want 0", bus.ovf);
    end
`endif
    run_frame(18'h03000, 4, 4, 2'd2, 0, 1'b0, 1'b0, "after_clear");
  endtask

  task automatic test_wrap();
    run_frame(18'h3FFFE, 2, 2, 2'd2, 2, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_start_ignored();
    run_frame(18'h04000, 3, 4, 2'd1, 0, 1'b1, 1'b0, "start_mid_frame");
  endtask

  task automatic test_restart_in_done();
    logic [ADDR_W-1:0] held;
    held          = bus.r_addr;
    bus.width     = 16'd2;
    bus.height    = 16'd6;
    bus.mode      = 2'd0;
    bus.base_addr = 18'h05000;
    bus.start     = 1'b1;
    bus.count_en  = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.r_addr !== held) begin
      errors++;
      $display("FAIL restart_addr: got %h want %h", bus.r_addr, held);
    end
    run_frame(18'h05000, 2, 6, 2'd0, 2, 1'b0, 1'b1, "restart");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run_frame(ADDR_W'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                2'($urandom_range(0, 3)), 2, 1'(k % 2), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_420();
    test_mono_toggle();
    test_empty_pixels();
    test_clear_mid_frame();
    test_wrap();
    test_start_ignored();
    test_restart_in_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
